alkshseq: RTL
=============

Name: alkshseq

Overview:
- Shift sequencer and shift-in source for the ALK ALU shift path on the DPM.
- Drives the shift-enable and shift-in lines into the ALU_SIO pad routing logic. Consumes the shifted-out bits that come back from that logic.
- Performs multi-bit shifts one bit per cycle under a start/done handshake. Supports logical, arithmetic, rotate and link-fill modes, and produces last-out and lost-bit status for the condition-code logic.

Parameters:
- CNT_W, 6, width of the shift count; counts above 32 are clamped to 32.

Ports:
- clk_h  in  1  single clock; all state changes on the rising edge
- reset_h  in  1  synchronous, active-high reset
- start_h  in  1  request a shift; sampled only in IDLE
- dir_left_h  in  1  1 = shift left, 0 = shift right; sampled at start
- mode_h  in  2  fill mode, sampled at start: 00 logical, 01 arithmetic, 10 rotate, 11 link
- count_h  in  CNT_W  number of bit positions; sampled at start
- sign_h  in  1  current ALU[31]; sampled at start
- link_in_h  in  1  external link/carry bit; sampled at start
- alu_sout_shl_h  in  1  bit leaving ALU[31] on a left shift
- alu_sout_shr_h  in  1  bit leaving ALU[0] on a right shift
- alu_shl_en_h  out  1  left-shift enable for the current cycle
- alu_shr_en_h  out  1  right-shift enable for the current cycle
- alu_sin_h  out  1  bit to shift into the vacated ALU position
- busy_h  out  1  high from the cycle after start through the DONE cycle
- done_h  out  1  single-cycle completion pulse
- last_out_h  out  1  last bit shifted out (carry-style)
- lost_h  out  1  sticky bits-lost / overflow flag

Behaviour:
- Reset: reset_h high at an edge forces IDLE and clears the counter, the sampled controls and both flags. All outputs are 0 in the following cycle. Reset wins over start_h and over an in-progress shift (abort, no done_h).
- States:
  - IDLE: busy_h=0, both enables 0. start_h=1 samples dir/mode/count/sign/link, clears last_out and lost, and loads the counter with min(count_h,32). Next state is SHIFT if the clamped count is nonzero, otherwise DONE.
  - SHIFT: busy_h=1. Exactly one of alu_shl_en_h / alu_shr_en_h is high, per the sampled direction. Each cycle:
    - last_out <= the active sout line;
    - lost is updated per the lost rule below;
    - the counter decrements;
    - when the counter equals 1 at the edge, next state is DONE.
  - DONE: done_h=1, busy_h=1, enables 0. Next state is IDLE unconditionally.
- Latency: with start sampled at edge N, shift cycles occupy N+1..N+k and done_h is asserted in cycle N+k+1, where k is the clamped count. k=0 gives done_h in cycle N+1, no enables, and last_out=lost=0.
- start_h outside IDLE, including during DONE, is ignored. No queuing.
- alu_sin_h is combinational and forced to 0 whenever neither enable is high. While shifting:
  - logical: 0.
  - arithmetic: sampled sign when shifting right; 0 when shifting left.
  - rotate: the current active sout (left uses alu_sout_shl_h, right uses alu_sout_shr_h). This is a combinational sout→sin path; sout reflects the pre-shift ALU value, so it is not a loop.
  - link: sampled link_in.
- lost rule:
  - right shift, any mode except rotate: lost |= sout.
  - left shift, arithmetic: lost |= (sout != sampled sign).
  - left shift, logical or link: lost |= sout.
  - rotate: lost stays 0.
- last_out_h and lost_h hold their values from DONE through IDLE until the next accepted start.
- Count clamp: count_h ≥ 32 behaves as 32. For rotate, 32 rotates return the original value.

Decomposition:
- Shared package (ucodedef-style constants): the mode encodings SHM_LOG=2'b00, SHM_ARI=2'b01, SHM_ROT=2'b10, SHM_LNK=2'b11; the state encodings IDLE/SHIFT/DONE; the clamp limit of 32.
- One natural sub-module, alkshfill: combinational fill-bit select (mode, dir, sign, link, souts → alu_sin_h) plus the lost-bit update term. The FSM and counter stay in alkshseq.

Test Plan:
- Reset then idle → all outputs 0. Assert reset_h mid-SHIFT (count=10, cycle 4) → next cycle IDLE, enables 0, no done_h.
- Logical right, count=3, sout_shr pattern 1,0,1 → shr_en high for 3 cycles, sin=0, done_h at start+4, last_out=1, lost=1.
- Arithmetic right, sign_h=1, count=2 → sin=1 in both shift cycles. With sout_shr 0,0 → lost=0.
- Arithmetic left, sign_h=0, count=2, sout_shl 0,1 → sin=0, lost=1, last_out=1.
- Rotate left, count=40 (clamped) → shl_en high for exactly 32 cycles, and sin tracks alu_sout_shl_h each cycle. Rotate right count=5 → sin tracks alu_sout_shr_h; lost=0.
- count=0 start → done_h the next cycle with no enables. start_h held high through DONE is not re-accepted until IDLE.

Source files
------------

// File: rtl/alkshseq_pkg.sv
// Shared constants for the ALK shift sequencer: fill-mode codes, FSM states
// and the shift-count ceiling.
package alkshseq_pkg;

  localparam logic [1:0] SHM_LOG = 2'b00;
  localparam logic [1:0] SHM_ARI = 2'b01;
  localparam logic [1:0] SHM_ROT = 2'b10;
  localparam logic [1:0] SHM_LNK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // A 32-bit ALU never needs more than 32 single-bit steps.
  localparam int unsigned SH_CLAMP = 32;

endpackage

// File: rtl/alkshfill.sv
// Fill-bit select for the ALU shift path plus the per-cycle lost-bit term.
// Purely combinational; the sequencer owns all state.
module alkshfill
  import alkshseq_pkg::*;
(
  input  logic       shifting,
  input  logic       dir_left,
  input  logic [1:0] mode,
  input  logic       sign,
  input  logic       link,
  input  logic       sout_shl,
  input  logic       sout_shr,
  output logic       sout_act,
  output logic       sin,
  output logic       lost_term
);

  // Pick the shift-in bit and the overflow contribution for this cycle.
  always_comb begin
    sout_act  = dir_left ? sout_shl : sout_shr;
    sin       = 1'b0;
    lost_term = 1'b0;
    if (shifting) begin
      case (mode)
        SHM_LOG: begin
          sin       = 1'b0;
          lost_term = sout_act;
        end
        SHM_ARI: begin
          // Right shifts replicate the sign; a left shift overflows whenever
          // the departing bit differs from the sign it should have matched.
          sin       = dir_left ? 1'b0 : sign;
          lost_term = dir_left ? (sout_act ^ sign) : sout_act;
        end
        SHM_ROT: begin
          // sout is taken from the pre-shift ALU value, so this is not a loop.
          sin       = sout_act;
          lost_term = 1'b0;
        end
        default: begin
          sin       = link;
          lost_term = sout_act;
        end
      endcase
    end
  end

endmodule

// File: rtl/alkshseq.sv
// ALK ALU shift sequencer: accepts a shift request, steps the ALU one bit
// per cycle, sources the fill bit and tracks last-out / lost status.
module alkshseq
  import alkshseq_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic             dir_left_h,
  input  logic [1:0]       mode_h,
  input  logic [CNT_W-1:0] count_h,
  input  logic             sign_h,
  input  logic             link_in_h,
  input  logic             alu_sout_shl_h,
  input  logic             alu_sout_shr_h,
  output logic             alu_shl_en_h,
  output logic             alu_shr_en_h,
  output logic             alu_sin_h,
  output logic             busy_h,
  output logic             done_h,
  output logic             last_out_h,
  output logic             lost_h
);

  // Counter must hold the clamp value even if CNT_W is configured narrower.
  localparam int CW = (CNT_W > 6) ? CNT_W : 6;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] count_ext;
  logic [CW-1:0] count_clamp;
  logic          dir_q;
  logic [1:0]    mode_q;
  logic          sign_q;
  logic          link_q;
  logic          last_q;
  logic          lost_q;
  logic          shl_en_q;
  logic          shr_en_q;
  logic          busy_q;
  logic          done_q;
  logic          sout_act;
  logic          lost_term;

  assign count_ext   = CW'(count_h);
  assign count_clamp = (count_ext >= CW'(SH_CLAMP)) ? CW'(SH_CLAMP) : count_ext;

  alkshfill u_fill (
    .shifting  (shl_en_q | shr_en_q),
    .dir_left  (dir_q),
    .mode      (mode_q),
    .sign      (sign_q),
    .link      (link_q),
    .sout_shl  (alu_sout_shl_h),
    .sout_shr  (alu_sout_shr_h),
    .sout_act  (sout_act),
    .sin       (alu_sin_h),
    .lost_term (lost_term)
  );

  // Sequencer FSM: sample on start, shift until the counter drains, pulse done.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dir_q    <= 1'b0;
      mode_q   <= SHM_LOG;
      sign_q   <= 1'b0;
      link_q   <= 1'b0;
      last_q   <= 1'b0;
      lost_q   <= 1'b0;
      shl_en_q <= 1'b0;
      shr_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_h) begin
            dir_q  <= dir_left_h;
            mode_q <= mode_h;
            sign_q <= sign_h;
            link_q <= link_in_h;
            last_q <= 1'b0;
            lost_q <= 1'b0;
            cnt    <= count_clamp;
            busy_q <= 1'b1;
            if (count_clamp != '0) begin
              state    <= ST_SHIFT;
              shl_en_q <= dir_left_h;
              shr_en_q <= ~dir_left_h;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          last_q <= sout_act;
          lost_q <= lost_q | lost_term;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= ST_DONE;
            shl_en_q <= 1'b0;
            shr_en_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          shl_en_q <= 1'b0;
          shr_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign alu_shl_en_h = shl_en_q;
  assign alu_shr_en_h = shr_en_q;
  assign busy_h       = busy_q;
  assign done_h       = done_q;
  assign last_out_h   = last_q;
  assign lost_h       = lost_q;

endmodule
